vec_1_scan_ctrl: RTL

VEC_1_SCAN_CTRL -- requirements
Module: vec_1_scan_ctrl

---
 rtl/vec_1_pkg.sv | 19 +
 rtl/vec_1_detector.sv | 17 +
 rtl/vec_1_scan_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/vec_1_pkg.sv
// Shared constants, FSM state encoding and a bit-count helper for the vec_1 set-bit scanner.
package vec_1_pkg;

  localparam int DATA_W = 32;
  localparam int POS_W  = 6;
  localparam logic [POS_W-1:0] NONE_POS = 6'd32;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SCAN  = 2'b01,
    EMPTY = 2'b10
  } state_e;

  // True when exactly one bit of v is set; drives out_last while scanning.
  function automatic logic is_single_bit(input logic [DATA_W-1:0] v);
    return (v != '0) && ((v & (v - DATA_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/vec_1_detector.sv
// Highest-set-bit detector: returns the index of the top set bit, or NONE_POS for an all-zero input.
module vec_1_detector
  import vec_1_pkg::*;
(
  input  logic [DATA_W-1:0] data_in,
  output logic [POS_W-1:0]  pos_out
);

  // Ascending scan; the last hit is the most significant set bit.
  always_comb begin
    pos_out = NONE_POS;
    for (int i = 0; i < DATA_W; i++) begin
      if (data_in[i]) pos_out = POS_W'(i);
    end
  end

endmodule

// File: rtl/vec_1_scan_ctrl.sv
// Enumerates the set bits of an accepted vector, highest index first, one beat per out handshake.
// Optional feature: define VEC1_SCAN_ABORT_EN to add the abort input.
module vec_1_scan_ctrl #(
  parameter int DATA_W = 32,
  parameter int POS_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef VEC1_SCAN_ABORT_EN
  input  logic              abort,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        out_pos,
  output logic              out_last,
  output logic              out_none,
  output logic [POS_W-1:0]  out_cnt
);
  import vec_1_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and outputs hold stable while valid is high and ready low.

  state_e            state_q, state_d;
  logic [DATA_W-1:0] residual_q, residual_d;
  logic [POS_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_none_q, out_none_d;
  logic [POS_W-1:0]  det_pos;
  logic              last_w;
  logic              in_hs;
  logic              out_hs;

  vec_1_detector u_detector (
    .data_in (residual_q),
    .pos_out (det_pos)
  );

  assign last_w = is_single_bit(residual_q);
  assign in_hs  = in_valid & in_ready_q;
  assign out_hs = out_valid_q & out_ready;

  always_comb begin
    state_d    = state_q;
    residual_d = residual_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_hs) begin
          cnt_d = '0;
          if (in_data != '0) begin
            residual_d = in_data;
            state_d    = SCAN;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      SCAN: begin
        // An empty residual while scanning can only come from corruption; bail out to IDLE.
        if (det_pos == NONE_POS) begin
          state_d    = IDLE;
          residual_d = '0;
        end else if (out_hs) begin
          residual_d[det_pos[4:0]] = 1'b0;
          cnt_d = cnt_q + POS_W'(1);
          if (last_w) state_d = IDLE;
        end
      end
      EMPTY: begin
        if (out_hs) state_d = IDLE;
      end
      default: begin
        state_d    = IDLE;
        residual_d = '0;
      end
    endcase
`ifdef VEC1_SCAN_ABORT_EN
    // Abort wins over a same-cycle beat: the count is left where it was.
    if (abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      residual_d = '0;
      cnt_d      = cnt_q;
    end
`endif
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d != IDLE);
    out_none_d  = (state_d == EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      residual_q  <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_none_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      residual_q  <= residual_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_none_q  <= out_none_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_none  = out_none_q;
  assign out_cnt   = cnt_q;
  assign out_pos   = (state_q == SCAN) ? det_pos[4:0] : 5'd0;
  assign out_last  = ((state_q == SCAN) && last_w) || (state_q == EMPTY);

endmodule
